// File: rtl/h80bus_pkg.sv
// ============================================================================
// Module      : h80bus_pkg
// Description : Shared h80 bus definitions: command encodings (cmd[0] = 1 for
//               reads), the data-port transfer size enum, default bus widths
//               and small helpers for command selection and alignment checks.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package h80bus_pkg;

    localparam int c_BUS_ADDR_WIDTH = 16;
    localparam int c_BUS_DATA_WIDTH = 32;
    localparam int c_BUS_CMD_WIDTH  = 3;

    // Bit 0 set marks a read; the slave drives data_ only for those.
    localparam logic [2:0] c_bus_cmd_write   = 3'b000;
    localparam logic [2:0] c_bus_cmd_read    = 3'b001;
    localparam logic [2:0] c_bus_cmd_write_w = 3'b010;
    localparam logic [2:0] c_bus_cmd_read_w  = 3'b011;
    localparam logic [2:0] c_bus_cmd_write_b = 3'b100;
    localparam logic [2:0] c_bus_cmd_read_b  = 3'b101;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'b00,
        SIZE_WORD = 2'b01,
        SIZE_LONG = 2'b10,
        SIZE_RSVD = 2'b11
    } size_e;

    // Bus command for a data-port access of the given size and direction.
    function automatic logic [2:0] size_to_cmd(input size_e size, input logic we);
        logic [2:0] cmd;
        case (size)
            SIZE_BYTE: cmd = we ? c_bus_cmd_write_b : c_bus_cmd_read_b;
            SIZE_WORD: cmd = we ? c_bus_cmd_write_w : c_bus_cmd_read_w;
            default:   cmd = we ? c_bus_cmd_write   : c_bus_cmd_read;
        endcase
        return cmd;
    endfunction

    // Reserved size, or a multi-byte access starting on an odd address.
    function automatic logic data_req_rejected(input size_e size, input logic addr_lsb);
        return (size == SIZE_RSVD) || ((size != SIZE_BYTE) && addr_lsb);
    endfunction

endpackage

`default_nettype wire

// File: rtl/h80cpu_biu.sv
// ============================================================================
// Module      : h80cpu_biu
// Description : Bus interface unit between the h80 CPU core and the h80 bus.
//               Arbitrates instruction-fetch and data requests (data wins),
//               runs one bus cycle at a time and returns read data plus an
//               ack/err pulse to the requester.
// Revision    : 1.0 - initial release
//
// Ports:
//   clk, reset_n           system clock, asynchronous active-low reset
//   if_req/if_addr         fetch request (level) and byte address
//   if_ack/if_rdata/if_err fetch completion pulse, fetched long, error
//   d_req/d_we/d_size      data request (level), write flag, transfer size
//   d_addr/d_wdata         data byte address, right-aligned write data
//   d_ack/d_rdata/d_err    data completion pulse, read data, error
//   ce_n/addr/cmd          h80 bus select (active-low), address, command
//   data_                  h80 bus data, driven only for writes while ce_n=0
//   wait_n                 slave stall, active-low
// ============================================================================
`default_nettype none

module h80cpu_biu
    import h80bus_pkg::*;
#(
    parameter int BUS_ADDR_WIDTH = c_BUS_ADDR_WIDTH,
    parameter int BUS_CMD_WIDTH  = c_BUS_CMD_WIDTH,
    parameter int BUS_DATA_WIDTH = c_BUS_DATA_WIDTH,
    parameter int TIMEOUT        = 64
) (
    input  logic                      clk,
    input  logic                      reset_n,
    // instruction fetch port
    input  logic                      if_req,
    input  logic [BUS_ADDR_WIDTH-1:0] if_addr,
    output logic                      if_ack,
    output logic [BUS_DATA_WIDTH-1:0] if_rdata,
    output logic                      if_err,
    // data port
    input  logic                      d_req,
    input  logic                      d_we,
    input  logic [1:0]                d_size,
    input  logic [BUS_ADDR_WIDTH-1:0] d_addr,
    input  logic [BUS_DATA_WIDTH-1:0] d_wdata,
    output logic                      d_ack,
    output logic [BUS_DATA_WIDTH-1:0] d_rdata,
    output logic                      d_err,
    // h80 bus
    output logic                      ce_n,
    output logic [BUS_ADDR_WIDTH-1:0] addr,
    output logic [BUS_CMD_WIDTH-1:0]  cmd,
    inout  wire  [BUS_DATA_WIDTH-1:0] data_,
    input  logic                      wait_n
);

    // Counter must hold TIMEOUT-1; keep at least one bit when disabled.
    localparam int c_TO_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [c_TO_W-1:0] c_TO_LAST = (TIMEOUT > 0) ? c_TO_W'(TIMEOUT - 1) : '0;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DATA   = 2'd2,
        ST_RESP   = 2'd3
    } state_e;

    state_e                    r_state;
    logic                      r_ce_n;
    logic [BUS_ADDR_WIDTH-1:0] r_addr;
    logic [BUS_CMD_WIDTH-1:0]  r_cmd;
    logic [BUS_DATA_WIDTH-1:0] r_wdata;
    logic                      r_sel_d;     // current cycle belongs to the data port
    logic                      r_if_ack;
    logic                      r_if_err;
    logic [BUS_DATA_WIDTH-1:0] r_if_rdata;
    logic                      r_d_ack;
    logic                      r_d_err;
    logic [BUS_DATA_WIDTH-1:0] r_d_rdata;
    logic [c_TO_W-1:0]         r_to_cnt;

    size_e                     w_d_size;
    logic                      w_d_bad;
    logic                      w_if_bad;
    logic [2:0]                w_d_cmd;
    logic                      w_data_oe;
    logic                      w_timeout;

    assign w_d_size  = size_e'(d_size);
    assign w_d_bad   = data_req_rejected(w_d_size, d_addr[0]);
    assign w_if_bad  = if_addr[0];
    assign w_d_cmd   = size_to_cmd(w_d_size, d_we);
    assign w_timeout = (TIMEOUT != 0) && (r_to_cnt == c_TO_LAST);

    // Enable decoded from registered ce_n/cmd so it drops with async reset.
    assign w_data_oe = !r_ce_n && !r_cmd[0];
    assign data_     = w_data_oe ? r_wdata : {BUS_DATA_WIDTH{1'bz}};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_ce_n     <= 1'b1;
            r_addr     <= '0;
            r_cmd      <= '0;
            r_wdata    <= '0;
            r_sel_d    <= 1'b0;
            r_if_ack   <= 1'b0;
            r_if_err   <= 1'b0;
            r_if_rdata <= '0;
            r_d_ack    <= 1'b0;
            r_d_err    <= 1'b0;
            r_d_rdata  <= '0;
            r_to_cnt   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (d_req) begin
                        r_sel_d <= 1'b1;
                        if (w_d_bad) begin
                            // Rejected without touching the bus.
                            r_state <= ST_RESP;
                            r_d_ack <= 1'b1;
                            r_d_err <= 1'b1;
                        end else begin
                            r_state <= ST_ACCESS;
                            r_ce_n  <= 1'b0;
                            r_addr  <= d_addr;
                            r_cmd   <= BUS_CMD_WIDTH'(w_d_cmd);
                            r_wdata <= d_wdata;
                        end
                    end else if (if_req) begin
                        r_sel_d <= 1'b0;
                        if (w_if_bad) begin
                            r_state  <= ST_RESP;
                            r_if_ack <= 1'b1;
                            r_if_err <= 1'b1;
                        end else begin
                            r_state <= ST_ACCESS;
                            r_ce_n  <= 1'b0;
                            r_addr  <= if_addr;
                            r_cmd   <= BUS_CMD_WIDTH'(c_bus_cmd_read);
                        end
                    end
                end

                ST_ACCESS: begin
                    if (wait_n) begin
                        r_to_cnt <= '0;
                        if (r_cmd[0]) begin
                            r_state <= ST_DATA;
                        end else begin
                            r_state <= ST_RESP;
                            r_ce_n  <= 1'b1;
                            r_d_ack <= r_sel_d;
                            r_if_ack <= !r_sel_d;
                        end
                    end else if (w_timeout) begin
                        // Abort: release the bus and report an error.
                        r_to_cnt <= '0;
                        r_state  <= ST_RESP;
                        r_ce_n   <= 1'b1;
                        r_d_ack  <= r_sel_d;
                        r_d_err  <= r_sel_d;
                        r_if_ack <= !r_sel_d;
                        r_if_err <= !r_sel_d;
                    end else begin
                        r_to_cnt <= r_to_cnt + 1'b1;
                    end
                end

                ST_DATA: begin
                    r_state  <= ST_RESP;
                    r_ce_n   <= 1'b1;
                    r_d_ack  <= r_sel_d;
                    r_if_ack <= !r_sel_d;
                    if (r_sel_d) begin
                        r_d_rdata <= data_;
                    end else begin
                        r_if_rdata <= data_;
                    end
                end

                ST_RESP: begin
                    // Requests are not sampled here; the requester drops or
                    // replaces its request during this ack cycle.
                    r_state  <= ST_IDLE;
                    r_d_ack  <= 1'b0;
                    r_d_err  <= 1'b0;
                    r_if_ack <= 1'b0;
                    r_if_err <= 1'b0;
                end

                default: begin
                    r_state <= ST_IDLE;
                    r_ce_n  <= 1'b1;
                end
            endcase
        end
    end

    assign ce_n     = r_ce_n;
    assign addr     = r_addr;
    assign cmd      = r_cmd;
    assign if_ack   = r_if_ack;
    assign if_err   = r_if_err;
    assign if_rdata = r_if_rdata;
    assign d_ack    = r_d_ack;
    assign d_err    = r_d_err;
    assign d_rdata  = r_d_rdata;

endmodule

`default_nettype wire

// File: doc/h80cpu_biu.md
# h80cpu_biu

Bus interface unit between the h80 CPU core and the h80 bus. Accepts instruction-fetch and data-access requests from the core, arbitrates them, and runs one h80 bus cycle at a time (ce_n/addr/cmd/data_/wait_n) against bus slaves such as the 32K-word memory. Returns read data and completion or error status to the requester.

## Interface
- BUS_ADDR_WIDTH, 16: byte address width.
- BUS_CMD_WIDTH, 3: bus command width.
- BUS_DATA_WIDTH, 32: bus and request data width.
- TIMEOUT, 64: maximum wait_n-low cycles before abort; 0 disables the timeout.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
  - clk  in  1  system clock.
  - reset_n  in  1  asynchronous, active-low reset.
- Instruction fetch port:
  - if_req  in  1  fetch request (level).
  - if_addr  in  BUS_ADDR_WIDTH  fetch byte address.
  - if_ack  out  1  one-cycle completion pulse.
  - if_rdata  out  BUS_DATA_WIDTH  fetched long.
  - if_err  out  1  valid with if_ack.
- Data port:
  - d_req  in  1  data request (level).
  - d_we  in  1  1 = write.
  - d_size  in  2  00 = byte, 01 = word, 10 = long, 11 = reserved.
  - d_addr  in  BUS_ADDR_WIDTH  byte address.
  - d_wdata  in  BUS_DATA_WIDTH  write data, right-aligned.
  - d_ack  out  1  one-cycle completion pulse.
  - d_rdata  out  BUS_DATA_WIDTH  read data (zero-extended by the slave).
  - d_err  out  1  valid with d_ack.
- h80 bus:
  - ce_n  out  1  bus select, active-low.
  - addr  out  BUS_ADDR_WIDTH  bus address.
  - cmd  out  BUS_CMD_WIDTH  bus_cmd_* encoding; cmd[0] = 1 means read.
  - data_  inout  BUS_DATA_WIDTH  driven by the BIU only while ce_n = 0 and cmd[0] = 0, otherwise high-Z.
  - wait_n  in  1  slave stall, active-low.

## Operation
- States:
  - IDLE: ce_n = 1; samples requests.
  - ACCESS: ce_n = 0; addr/cmd held stable.
  - DATA: ce_n = 0; read only.
  - RESP: ce_n = 1; ack pulses.
- Arbitration happens in IDLE at the clock edge. Fixed priority: data over fetch. The losing request stays pending. No preemption of a running cycle.
- Size-to-command mapping:
  - d_size 00 maps to bus_cmd_read_b / bus_cmd_write_b.
  - d_size 01 maps to read_w / write_w.
  - d_size 10 maps to read / write.
  - A fetch is always bus_cmd_read.
- Alignment check, done in IDLE with no bus cycle issued:
  - A word or long with addr[0] = 1 is rejected.
  - A fetch with if_addr[0] = 1 is rejected.
  - d_size 11 is rejected.
  - A rejected request goes IDLE→RESP with err = 1 and rdata unchanged.
- Write path:
  - IDLE→ACCESS. data_ is driven with d_wdata during ACCESS.
  - At an edge with wait_n = 1: go to RESP.
- Read path:
  - IDLE→ACCESS. At an edge with wait_n = 1: go to DATA.
  - In DATA, ce_n stays low while the slave drives data_.
  - At the end of DATA, data_ is captured into if_rdata or d_rdata, then go to RESP.
- RESP: the selected ack is high for exactly one cycle, then IDLE. Requests are never sampled in RESP.
- Timeout:
  - A counter increments on each ACCESS cycle with wait_n = 0.
  - When it reaches TIMEOUT: ce_n is released, go to RESP with err = 1, rdata unchanged.
  - The counter clears on leaving ACCESS.
- Requester rule: deassert req, or present the next request, by the end of the ack cycle. A req high at an IDLE edge is a new request.

## Timing
- Reset values (asynchronous):
  - state IDLE; ce_n = 1; addr = 0; cmd = 0; data_ high-Z.
  - all acks and errs = 0; if_rdata = d_rdata = 0; timeout counter = 0.
- All outputs are registered except data_ enable, which is decoded from the registered ce_n/cmd.
- Latency from req sampled at an IDLE edge (cycle 0), with wait_n high:
  - Read: ACCESS in cycle 1, DATA in cycle 2, ack in cycle 3.
  - Write: ACCESS in cycle 1, ack in cycle 2.
  - Misaligned or reserved request: ack with err in cycle 1.
- Each wait_n-low edge in ACCESS adds one cycle.
- Maximum throughput for back-to-back requests:
  - Reads: one per 4 cycles.
  - Writes: one per 3 cycles.
- If reset_n is asserted mid-cycle, the bus is released immediately (ce_n = 1, data_ Z) and no ack is issued.
- if_req and d_req both high in IDLE: the data request is served and the fetch follows after RESP.

## Structure
- The shared package h80bus_pkg holds:
  - the bus_cmd_* encodings (read/write/read_w/write_w/read_b/write_b, with cmd[0] = 1 for reads);
  - the size enum;
  - BUS_ADDR_WIDTH/BUS_DATA_WIDTH defaults.
- The state enum is local to the module.
- Single module. The timeout counter is inline and needs no sub-module.

## Test plan
- Data long write followed by a read, using the memory model as slave:
  - d_addr = 16'h0100, d_wdata = 32'h DEADBEEF writes, with d_ack at cycle 2.
  - A read of 16'h0100 returns d_rdata = 32'h DEADBEEF, with d_ack at cycle 3 and no error.
- Byte write 8'h5A to 16'h0101, then a word read of 16'h0100 returns 16'h5AEF (upper bits 0).
- if_req and d_req asserted in the same cycle: the data bus cycle comes first, then the fetch; exactly one ack per port.
- Slave holds wait_n low for 3 cycles on a read: ce_n stays low and addr/cmd stay stable, and the ack arrives at cycle 6.
- Misaligned and reserved requests: word read of 16'h0003 gives d_ack + d_err at cycle 1 with no ce_n assertion; d_size = 11 does the same.
- Timeout and reset:
  - With TIMEOUT = 4 and wait_n stuck low: err is reported, ce_n is released, and the next request proceeds normally.
  - reset_n pulsed during DATA: ce_n = 1 and data_ Z immediately, with no ack.
